// File: rtl/dual_port_memory_pkg.sv
// Shared widths and word/address types for the dual-port memory slice.
package dual_port_memory_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int ADDR_W_DEFAULT = 4;

    typedef logic [DATA_W_DEFAULT-1:0] word_t;
    typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

endpackage : dual_port_memory_pkg

// File: rtl/dual_port_memory_if.sv
// Write port, read port and registered read result of the dual-port memory.
interface dual_port_memory_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;

    modport master (
        output wr_en, wr_addr, din, rd_en, rd_addr,
        input  dout, dout_valid
    );

    modport slave (
        input  wr_en, wr_addr, din, rd_en, rd_addr,
        output dout, dout_valid
    );

endinterface : dual_port_memory_if

// File: rtl/dpm_regfile.sv
// Storage array: synchronous clear, one write port, combinational read.
module dpm_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Address and data are only used under we_i, so X on them is harmless while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : dpm_regfile

// File: rtl/dual_port_memory.sv
// Simple dual-port RAM: posted writes, registered one-cycle reads, write-first on collision.
module dual_port_memory
    import dual_port_memory_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    dual_port_memory_if.slave  bus
);

    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_d;
    logic              dout_valid_q;
    logic              collide;

    dpm_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we_i    (bus.wr_en),
        .waddr_i (bus.wr_addr),
        .wdata_i (bus.din),
        .raddr_i (bus.rd_addr),
        .rdata_o (rd_word)
    );

    // Same-edge write to the address being read forwards the incoming word.
    assign collide = bus.wr_en && bus.rd_en && (bus.wr_addr == bus.rd_addr);

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (bus.rd_en) begin
            dout_valid_d = 1'b1;
            dout_d       = collide ? bus.din : rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule : dual_port_memory

// File: tb/tb_dual_port_memory.sv
// Directed self-checking bench for dual_port_memory.
module tb_dual_port_memory;
    import dual_port_memory_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dual_port_memory_if #(.DATA_W(DATA_W_DEFAULT), .ADDR_W(ADDR_W_DEFAULT)) bus ();

    dual_port_memory #(
        .DATA_W (DATA_W_DEFAULT),
        .ADDR_W (ADDR_W_DEFAULT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic wr(input addr_t a, input word_t d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.din     = d;
    endtask

    task automatic rd(input addr_t a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
    endtask

    task automatic read_expect(input string tag, input addr_t a, input word_t exp);
        idle();
        rd(a);
        step();
        check_eq({tag, "_data"}, bus.dout, exp);
        check_eq({tag, "_vld"}, bus.dout_valid, 1'b1);
        idle();
    endtask

    initial begin
        automatic addr_t sweep_a [3] = '{4'd0, 4'd7, 4'd15};
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.din     = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;

        // Reset for two cycles
        step();
        check_eq("rst1_dout", bus.dout, 8'h00);
        check_eq("rst1_vld", bus.dout_valid, 1'b0);
        step();
        check_eq("rst2_dout", bus.dout, 8'h00);
        check_eq("rst2_vld", bus.dout_valid, 1'b0);
        rst = 1'b0;

        foreach (sweep_a[k]) read_expect($sformatf("rst_rd%0d", sweep_a[k]), sweep_a[k], 8'h00);
        step();
        check_eq("idle_vld", bus.dout_valid, 1'b0);

        // Basic write then read
        wr(4'd2, 8'hA5);
        step();
        idle();
        step();
        step();
        read_expect("basic_rd2", 4'd2, 8'hA5);
        step();
        check_eq("basic_idle_vld", bus.dout_valid, 1'b0);
        check_eq("basic_idle_dout", bus.dout, 8'hA5);

        // Full sweep write then reverse back-to-back read
        for (int i = 0; i < 16; i++) begin
            wr(addr_t'(i), word_t'(8'h10 + i));
            step();
        end
        idle();
        for (int i = 15; i >= 0; i--) begin
            rd(addr_t'(i));
            step();
            check_eq($sformatf("sweep_d%0d", i), bus.dout, 8'h10 + i);
            check_eq($sformatf("sweep_v%0d", i), bus.dout_valid, 1'b1);
        end
        idle();
        step();
        check_eq("sweep_end_vld", bus.dout_valid, 1'b0);
        check_eq("sweep_end_dout", bus.dout, 8'h10);

        // Collision: write-first
        wr(4'd5, 8'h33);
        step();
        idle();
        wr(4'd5, 8'hC3);
        rd(4'd5);
        step();
        check_eq("coll_dout", bus.dout, 8'hC3);
        check_eq("coll_vld", bus.dout_valid, 1'b1);
        read_expect("coll_later", 4'd5, 8'hC3);

        // Independent ports on the same edge
        wr(4'd2, 8'hA5);
        step();
        idle();
        wr(4'd9, 8'h5A);
        rd(4'd2);
        step();
        check_eq("indep_dout", bus.dout, 8'hA5);
        check_eq("indep_vld", bus.dout_valid, 1'b1);
        read_expect("indep_rd9", 4'd9, 8'h5A);

        // Idle strobes with garbage on addresses/data change nothing
        idle();
        bus.wr_addr = 4'd9;
        bus.din     = 8'hEE;
        bus.rd_addr = 4'd3;
        step();
        check_eq("nostrobe_dout", bus.dout, 8'h5A);
        check_eq("nostrobe_vld", bus.dout_valid, 1'b0);
        read_expect("nostrobe_rd9", 4'd9, 8'h5A);
        read_expect("rd3_before_rst", 4'd3, 8'h13);

        // Reset priority over a concurrent write and read
        rst = 1'b1;
        wr(4'd3, 8'hFF);
        rd(4'd3);
        step();
        check_eq("rstpri_vld", bus.dout_valid, 1'b0);
        check_eq("rstpri_dout", bus.dout, 8'h00);
        rst = 1'b0;
        idle();
        step();
        read_expect("rstpri_rd3", 4'd3, 8'h00);
        read_expect("rstpri_rd9", 4'd9, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dual_port_memory
